homework_lut3: RTL and testbench
================================

Name: homework_lut3

Overview:
- Registered 3-input Boolean function unit. Inputs A1..A3 index an 8-entry truth table; Y is the selected bit, registered once.
- The truth table resets to a parameter value and can be reprogrammed at run time through a one-cycle write port.
- Serves as a small glue-logic and decision cell inside the lab datapath. The default function is 3-input majority.

Parameters:
- LUT_INIT, 8'hE8, truth-table value after reset. Bit i is Y for index i = {A1,A2,A3}, with A1 as MSB. The default is majority.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A1  input  1  function input, index bit 2 (MSB)
- A2  input  1  function input, index bit 1
- A3  input  1  function input, index bit 0 (LSB)
- cfg_we  input  1  truth-table write strobe, one cycle
- cfg_lut  input  8  new truth-table value, sampled when cfg_we=1
- lut_q  output  8  current truth-table register
- Y  output  1  registered function result
- y_rise  output  1  one-cycle pulse when Y goes 0->1

Behaviour:
- All state updates on the rising edge of clk. reset is synchronous and has priority over everything else.
- Reset values:
  - lut_q = LUT_INIT
  - Y = 0
  - y_rise = 0
  - statistics counter = 0 (when compiled in)
- Each non-reset cycle:
  - Y <= lut_q[{A1,A2,A3}].
  - Latency is one cycle from A* to Y; A* are sampled every cycle with no enable.
- Write port:
  - cfg_we=1 loads lut_q <= cfg_lut on the same edge.
  - On a simultaneous write and evaluation, Y uses the old lut_q. The new table takes effect for evaluations on the following edge.
  - Back-to-back writes are allowed; the last one wins.
- y_rise <= Y_next & ~Y. It is a registered pulse aligned with the Y rising edge and lasts exactly one cycle.
- Reset asserted mid-operation:
  - Y and y_rise drop to 0 at the next edge.
  - lut_q returns to LUT_INIT, discarding any programmed table.
  - A cfg_we in the same cycle as reset is ignored.
- Inputs have no X-propagation handling. The bench must drive known values.

Optional Feature:
- Macro HOMEWORK_LUT3_STATS_EN.
- When defined:
  - Adds output y_count (16-bit), counting the cycles where registered Y=1.
  - Increments on each edge where the new Y is 1.
  - Saturates at 16'hFFFF and does not wrap.
  - Clears on reset.
- When undefined, y_count does not exist and there is no counter logic.

Decomposition:
- Package homework_lut3_pkg holds:
  - LUT_W=8 and IDX_W=3
  - LUT_MAJORITY=8'hE8, LUT_AND3=8'h80, LUT_OR3=8'hFE, LUT_XOR3=8'h96
  - a function idx(A1,A2,A3) returning the 3-bit index
- One sub-module is natural: homework_lut3_stats, holding the saturating counter. It is instantiated only under the macro.

Test Plan:
- reset=1 for 2 cycles -> Y=0, y_rise=0, lut_q=8'hE8.
- Release reset; A1=1,A2=1,A3=0 -> next edge Y=1 and y_rise=1 for one cycle. Holding the inputs keeps Y=1 with y_rise=0.
- Sweep all 8 {A1,A2,A3} combinations with the default table -> Y=1 only for 011, 101, 110, 111, each one cycle after the input is applied.
- cfg_we=1, cfg_lut=8'h96 with A=110 on the same edge -> Y=1 (old table). Next edge with A=110 -> Y=0 (XOR table). With A=100 -> Y=1.
- Program 8'h80, then assert reset mid-stream while A=111 -> Y=0 after the reset edge and lut_q=8'hE8. A cfg_we in the reset cycle is ignored.
- With HOMEWORK_LUT3_STATS_EN:
  - Hold A=111 for 5 cycles -> y_count=5.
  - Force the counter to 16'hFFFE, then run 3 more Y=1 cycles -> y_count=16'hFFFF.

Source files
------------

// File: rtl/homework_lut3_pkg.sv
// Shared constants and helpers for the homework_lut3 registered 3-input
// Boolean function cell. Truth-table bit i is the output for index i, where
// the index is {A1,A2,A3} with A1 as the MSB.
package homework_lut3_pkg;

  localparam int LUT_W = 8;
  localparam int IDX_W = 3;

  // Frequently used truth tables.
  localparam logic [LUT_W-1:0] LUT_MAJORITY = 8'hE8;
  localparam logic [LUT_W-1:0] LUT_AND3     = 8'h80;
  localparam logic [LUT_W-1:0] LUT_OR3      = 8'hFE;
  localparam logic [LUT_W-1:0] LUT_XOR3     = 8'h96;

  // Truth-table index formed from the three function inputs, A1 as MSB.
  function automatic logic [IDX_W-1:0] idx(input logic a1, input logic a2,
                                           input logic a3);
    return {a1, a2, a3};
  endfunction

endpackage

// File: rtl/homework_lut3_stats.sv
// Saturating 16-bit counter of cycles on which the registered function
// output is 1. Instantiated by homework_lut3 only when
// HOMEWORK_LUT3_STATS_EN is defined.
module homework_lut3_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  // Count edges where the new Y is 1; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/homework_lut3.sv
// Registered 3-input Boolean function unit with a run-time programmable
// 8-entry truth table and a one-cycle rising-edge pulse on the output.
// Optional feature: define HOMEWORK_LUT3_STATS_EN to add y_count, a
// saturating count of cycles with Y=1.
module homework_lut3
  import homework_lut3_pkg::*;
#(
  parameter logic [LUT_W-1:0] LUT_INIT = LUT_MAJORITY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A1,
  input  logic             A2,
  input  logic             A3,
  input  logic             cfg_we,
  input  logic [LUT_W-1:0] cfg_lut,
  output logic [LUT_W-1:0] lut_q,
  output logic             Y,
  output logic             y_rise
`ifdef HOMEWORK_LUT3_STATS_EN
  ,
  output logic [15:0]      y_count
`endif
);

  // Lookup uses the table currently held in lut_q, so a write on the same
  // edge only affects evaluations from the following edge onwards.
  logic y_next;
  assign y_next = lut_q[idx(A1, A2, A3)];

  // Table register, registered function output and rising-edge pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every register here sample the
    // pre-edge values of the others (y_rise sees the old Y, Y the old table).
    if (reset) begin
      // NOTE: lut_q is a plain register, not a memory, so resetting it to
      // LUT_INIT is cheap and discards any programmed table.
      lut_q  <= LUT_INIT;
      Y      <= 1'b0;
      y_rise <= 1'b0;
    end else begin
      if (cfg_we) begin
        lut_q <= cfg_lut;
      end
      Y      <= y_next;
      y_rise <= y_next & ~Y;
    end
  end

`ifdef HOMEWORK_LUT3_STATS_EN
  homework_lut3_stats u_stats (
    .clk   (clk),
    .reset (reset),
    .inc   (y_next),
    .count (y_count)
  );
`endif

endmodule

// File: tb/tb_homework_lut3.sv
// Self-checking bench for homework_lut3. A behavioural model tracks the
// truth table, Y, y_rise and (with HOMEWORK_LUT3_STATS_EN) the Y=1 count,
// and each test task compares the DUT against it and against hand-derived
// constants.
module tb_homework_lut3;
  import homework_lut3_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       A1 = 1'b0, A2 = 1'b0, A3 = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_lut = 8'h00;
  logic [7:0] lut_q;
  logic       Y;
  logic       y_rise;
`ifdef HOMEWORK_LUT3_STATS_EN
  logic [15:0] y_count;
`endif

  homework_lut3 #(.LUT_INIT(8'hE8)) dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .cfg_we  (cfg_we),
    .cfg_lut (cfg_lut),
    .lut_q   (lut_q),
    .Y       (Y),
    .y_rise  (y_rise)
`ifdef HOMEWORK_LUT3_STATS_EN
    ,
    .y_count (y_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int unsigned m_lut = 32'hE8;
  bit          m_y   = 1'b0;
  bit          m_rise = 1'b0;
  int unsigned m_cnt = 0;

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1 time unit past the edge for sampling.
  task automatic cycle(input int a, input bit rst, input bit we,
                       input int unsigned lut);
    bit ny;
    reset   = rst;
    A1      = a[2];
    A2      = a[1];
    A3      = a[0];
    cfg_we  = we;
    cfg_lut = lut[7:0];
    @(posedge clk);
    if (rst) begin
      m_lut  = 32'hE8;
      m_y    = 1'b0;
      m_rise = 1'b0;
      m_cnt  = 0;
    end else begin
      ny     = ((m_lut >> a) & 1) == 1;
      m_rise = ny && !m_y;
      m_y    = ny;
      if (we) m_lut = lut & 8'hFF;
      if (ny && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1'b1, 1'b0, 0);
    cycle(0, 1'b1, 1'b1, 32'h55);
    n_total++;
    if (Y !== 1'b0) $display("FAIL reset_y: got %b want 0", Y); else n_pass++;
    n_total++;
    if (y_rise !== 1'b0) $display("FAIL reset_rise: got %b want 0", y_rise); else n_pass++;
    n_total++;
    if (lut_q !== 8'hE8) $display("FAIL reset_lut: got %h want e8", lut_q); else n_pass++;
  endtask

  task automatic test_rise();
    cycle(3'b110, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b1 || y_rise !== 1'b1)
      $display("FAIL rise_first: got Y=%b rise=%b want Y=1 rise=1", Y, y_rise);
    else n_pass++;
    cycle(3'b110, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b1 || y_rise !== 1'b0)
      $display("FAIL rise_hold: got Y=%b rise=%b want Y=1 rise=0", Y, y_rise);
    else n_pass++;
  endtask

  // Default table is majority: Y=1 exactly when two or more inputs are 1.
  task automatic test_sweep();
    for (int a = 0; a < 8; a++) begin
      bit exp_y;
      cycle(a, 1'b0, 1'b0, 0);
      exp_y = ($countones(a[2:0]) >= 2);
      n_total++;
      if (Y !== exp_y) $display("FAIL sweep_%0d: got %b want %b", a, Y, exp_y);
      else n_pass++;
      n_total++;
      if (y_rise !== m_rise)
        $display("FAIL sweep_rise_%0d: got %b want %b", a, y_rise, m_rise);
      else n_pass++;
    end
  endtask

  task automatic test_write();
    cycle(3'b110, 1'b0, 1'b1, LUT_XOR3);
    n_total++;
    if (Y !== 1'b1) $display("FAIL write_old_table: got %b want 1", Y); else n_pass++;
    n_total++;
    if (lut_q !== 8'h96) $display("FAIL write_lut: got %h want 96", lut_q); else n_pass++;
    cycle(3'b110, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b0) $display("FAIL write_xor_110: got %b want 0", Y); else n_pass++;
    cycle(3'b100, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b1 || y_rise !== 1'b1)
      $display("FAIL write_xor_100: got Y=%b rise=%b want Y=1 rise=1", Y, y_rise);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cycle(0, 1'b0, 1'b1, LUT_AND3);
    cycle(0, 1'b0, 1'b1, LUT_OR3);
    n_total++;
    if (lut_q !== 8'hFE) $display("FAIL b2b_lut: got %h want fe", lut_q); else n_pass++;
    cycle(3'b001, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b1) $display("FAIL b2b_last_wins: got %b want 1", Y); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(3'b111, 1'b0, 1'b1, LUT_AND3);
    cycle(3'b111, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b1) $display("FAIL mid_and_111: got %b want 1", Y); else n_pass++;
    cycle(3'b111, 1'b1, 1'b1, LUT_OR3);
    n_total++;
    if (Y !== 1'b0 || y_rise !== 1'b0)
      $display("FAIL mid_reset_out: got Y=%b rise=%b want 0 0", Y, y_rise);
    else n_pass++;
    n_total++;
    if (lut_q !== 8'hE8) $display("FAIL mid_reset_lut: got %h want e8", lut_q); else n_pass++;
    // Majority gives 0 for 001; the discarded OR3 write would give 1.
    cycle(3'b001, 1'b0, 1'b0, 0);
    n_total++;
    if (Y !== 1'b0) $display("FAIL mid_we_ignored: got %b want 0", Y); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      bit rst = ($urandom_range(0, 39) == 0);
      bit we  = ($urandom_range(0, 5) == 0);
      cycle($urandom_range(0, 7), rst, we, $urandom_range(0, 255));
      if (Y !== m_y || y_rise !== m_rise || lut_q !== m_lut[7:0]) begin
        if (errs < 5)
          $display("FAIL random_%0d: got Y=%b rise=%b lut=%h want Y=%b rise=%b lut=%h",
                   i, Y, y_rise, lut_q, m_y, m_rise, m_lut[7:0]);
        errs++;
      end
`ifdef HOMEWORK_LUT3_STATS_EN
      if (y_count !== m_cnt[15:0]) begin
        if (errs < 5)
          $display("FAIL random_count_%0d: got %0d want %0d", i, y_count, m_cnt);
        errs++;
      end
`endif
    end
    n_total++;
    if (errs == 0) n_pass++;
  endtask

`ifdef HOMEWORK_LUT3_STATS_EN
  task automatic test_stats();
    cycle(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) cycle(3'b111, 1'b0, 1'b0, 0);
    n_total++;
    if (y_count !== 16'd5) $display("FAIL stats_five: got %0d want 5", y_count);
    else n_pass++;
    // Run up to 16'hFFFE, then three more Y=1 cycles must saturate.
    for (int i = 5; i < 65534; i++) cycle(3'b111, 1'b0, 1'b0, 0);
    n_total++;
    if (y_count !== 16'hFFFE) $display("FAIL stats_fffe: got %h want fffe", y_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(3'b111, 1'b0, 1'b0, 0);
    n_total++;
    if (y_count !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", y_count);
    else n_pass++;
    cycle(0, 1'b1, 1'b0, 0);
    n_total++;
    if (y_count !== 16'd0) $display("FAIL stats_clear: got %h want 0", y_count);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_sweep();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef HOMEWORK_LUT3_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
